// File: rtl/hour_chime.sv
`default_nettype none
// ============================================================================
//  Module   : hour_chime
//  Purpose  : Hourly chime sequencer. When the current hour changes, flashes
//             time_light once per hour of the new time (12 h or 24 h
//             numbering), with configurable flash width, gap and an optional
//             quiet-hours window in which no chime starts.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ON_CYCLES    cycles time_light is high per flash (>= 1)
//    OFF_CYCLES   cycles time_light is low after each flash (>= 1)
//    QUIET_EN     1 enables quiet-hours suppression
//    QUIET_START  first suppressed hour (0..23)
//    QUIET_END    first non-suppressed hour after the window (0..23)
//  Ports
//    clk          system clock, rising edge
//    rst          asynchronous active-high reset
//    curHour      current hour, binary 0..23 (larger values are ignored)
//    enable       1 arms chiming; 0 aborts any sequence and blocks triggers
//    mode_12h     1 = 12 h flash count, 0 = 24 h; sampled on trigger only
//    time_light   registered chime output
//    busy         high while a sequence runs
//    chime_cnt    flashes still to start, including the current ON flash
//    done         one-cycle pulse when a sequence completes normally
// ============================================================================
module hour_chime #(
   parameter int ON_CYCLES   = 50_000_000,
   parameter int OFF_CYCLES  = 50_000_000,
   parameter int QUIET_EN    = 1,
   parameter int QUIET_START = 22,
   parameter int QUIET_END   = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] curHour,
   input  logic       enable,
   input  logic       mode_12h,
   output logic       time_light,
   output logic       busy,
   output logic [4:0] chime_cnt,
   output logic       done
);

   // Phase counter only ever counts up to the longer of the two phases minus
   // one, then is cleared, so clog2 of the longer phase is enough.
   localparam int PH_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_CYCLES - 1);
   localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2
   } state_t;

   state_t          state;
   logic [PH_W-1:0] phase;
   logic [7:0]      prev_hour;
   logic            primed;

   logic            quiet;
   logic            hour_valid;
   logic            trigger;
   logic [4:0]      hour5;
   logic [4:0]      hour_mod;
   logic [4:0]      flash_n;

   // -------------------------------------------------------------------------
   // Quiet-hours window. The window shape is fixed at elaboration time, so
   // only the comparison that applies is built.
   // -------------------------------------------------------------------------
   generate
      if (QUIET_EN != 0 && QUIET_START < QUIET_END) begin : g_quiet_span
         localparam logic [7:0] Q_START = 8'(QUIET_START);
         localparam logic [7:0] Q_END   = 8'(QUIET_END);
         assign quiet = (curHour >= Q_START) && (curHour < Q_END);
      end else if (QUIET_EN != 0 && QUIET_START > QUIET_END) begin : g_quiet_wrap
         // Window spans midnight.
         localparam logic [7:0] Q_START = 8'(QUIET_START);
         localparam logic [7:0] Q_END   = 8'(QUIET_END);
         assign quiet = (curHour >= Q_START) || (curHour < Q_END);
      end else begin : g_quiet_off
         assign quiet = 1'b0;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Flash count for the new hour. Only meaningful for valid hours (<= 23),
   // which is all the trigger ever lets through, so the low five bits suffice.
   // -------------------------------------------------------------------------
   assign hour5 = curHour[4:0];

   always_comb begin
      hour_mod = hour5;
      flash_n  = hour5;
      if (mode_12h) begin
         hour_mod = (hour5 >= 5'd12) ? (hour5 - 5'd12) : hour5;
         flash_n  = (hour_mod == 5'd0) ? 5'd12 : hour_mod;
      end else begin
         flash_n  = (hour5 == 5'd0) ? 5'd24 : hour5;
      end
   end

   // -------------------------------------------------------------------------
   // Trigger: a genuine hour change to a valid, non-quiet hour while armed.
   // primed keeps the first post-reset comparison (against the reset value of
   // prev_hour) from ever chiming.
   // -------------------------------------------------------------------------
   assign hour_valid = (curHour <= 8'd23);
   assign trigger    = primed && (curHour != prev_hour) && hour_valid &&
                       enable && !quiet;

   // -------------------------------------------------------------------------
   // Sequencer. Priority per edge: disable, then (re)trigger, then the normal
   // ON/OFF progression. A trigger coinciding with the end of a sequence wins,
   // so done only pulses when the sequence truly returns to IDLE.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         phase      <= '0;
         prev_hour  <= 8'd0;
         primed     <= 1'b0;
         time_light <= 1'b0;
         busy       <= 1'b0;
         chime_cnt  <= 5'd0;
         done       <= 1'b0;
      end else begin
         prev_hour <= curHour;
         primed    <= 1'b1;
         done      <= 1'b0;

         if (!enable) begin
            state      <= S_IDLE;
            phase      <= '0;
            time_light <= 1'b0;
            busy       <= 1'b0;
            chime_cnt  <= 5'd0;
         end else if (trigger) begin
            state      <= S_ON;
            phase      <= '0;
            time_light <= 1'b1;
            busy       <= 1'b1;
            chime_cnt  <= flash_n;
         end else begin
            case (state)
               S_ON: begin
                  if (phase == ON_LAST) begin
                     state      <= S_OFF;
                     phase      <= '0;
                     time_light <= 1'b0;
                     chime_cnt  <= chime_cnt - 5'd1;
                  end else begin
                     phase <= phase + 1'b1;
                  end
               end

               S_OFF: begin
                  if (phase == OFF_LAST) begin
                     phase <= '0;
                     if (chime_cnt == 5'd0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        state      <= S_ON;
                        time_light <= 1'b1;
                     end
                  end else begin
                     phase <= phase + 1'b1;
                  end
               end

               default: begin
                  state <= S_IDLE;
                  phase <= '0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hour_chime.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hour_chime
//  Purpose  : Directed self-checking bench for hour_chime with ON_CYCLES=2,
//             OFF_CYCLES=3. Two instances share all inputs: u_dut has the
//             22..7 quiet window enabled, u_loud has quiet hours disabled so
//             that hours inside the window can still be checked for their
//             flash count.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hour_chime;

   localparam int ON_C  = 2;
   localparam int OFF_C = 3;
   localparam int PER   = ON_C + OFF_C;

   logic       clk;
   logic       rst;
   logic [7:0] curHour;
   logic       enable;
   logic       mode_12h;

   logic       tl_q, busy_q, done_q;
   logic [4:0] cnt_q;
   logic       tl_l, busy_l, done_l;
   logic [4:0] cnt_l;

   int errors = 0;
   int checks = 0;

   hour_chime #(
      .ON_CYCLES   (ON_C),
      .OFF_CYCLES  (OFF_C),
      .QUIET_EN    (1),
      .QUIET_START (22),
      .QUIET_END   (7)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .curHour    (curHour),
      .enable     (enable),
      .mode_12h   (mode_12h),
      .time_light (tl_q),
      .busy       (busy_q),
      .chime_cnt  (cnt_q),
      .done       (done_q)
   );

   hour_chime #(
      .ON_CYCLES   (ON_C),
      .OFF_CYCLES  (OFF_C),
      .QUIET_EN    (0),
      .QUIET_START (22),
      .QUIET_END   (7)
   ) u_loud (
      .clk        (clk),
      .rst        (rst),
      .curHour    (curHour),
      .enable     (enable),
      .mode_12h   (mode_12h),
      .time_light (tl_l),
      .busy       (busy_l),
      .chime_cnt  (cnt_l),
      .done       (done_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Called right after the hour is changed on a falling edge. Sample i is
   // taken on the falling edge after rising edge k+i, where edge k is the
   // first edge that sees the new hour. Every cycle of time_light, busy,
   // chime_cnt and done is compared against the ideal waveform for n flashes.
   task automatic run_seq(input string tag, input int n_q, input int n_l, input int extra);
      int len;
      int bad_q;
      int bad_l;
      len   = ((n_q > n_l) ? n_q : n_l) * PER + extra;
      bad_q = 0;
      bad_l = 0;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (tl_q   !== exp_tl(i, n_q))   bad_q++;
         if (busy_q !== exp_busy(i, n_q)) bad_q++;
         if (cnt_q  !== exp_cnt(i, n_q))  bad_q++;
         if (done_q !== exp_done(i, n_q)) bad_q++;
         if (tl_l   !== exp_tl(i, n_l))   bad_l++;
         if (busy_l !== exp_busy(i, n_l)) bad_l++;
         if (cnt_l  !== exp_cnt(i, n_l))  bad_l++;
         if (done_l !== exp_done(i, n_l)) bad_l++;
      end
      check({tag, "_quiet_dut_bad_samples"}, bad_q, 0);
      check({tag, "_loud_dut_bad_samples"}, bad_l, 0);
   endtask

   function automatic logic exp_tl(input int i, input int n);
      return (i < n * PER) && ((i % PER) < ON_C);
   endfunction

   function automatic logic exp_busy(input int i, input int n);
      return (i < n * PER);
   endfunction

   function automatic logic exp_done(input int i, input int n);
      return (n > 0) && (i == n * PER);
   endfunction

   function automatic logic [4:0] exp_cnt(input int i, input int n);
      int v;
      if (i >= n * PER) return 5'd0;
      v = n - (i / PER) - (((i % PER) >= ON_C) ? 1 : 0);
      return 5'(v);
   endfunction

   initial begin
      rst      = 1'b1;
      curHour  = 8'd0;
      enable   = 1'b1;
      mode_12h = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset_time_light", int'(tl_q), 0);
      check("reset_busy", int'(busy_q), 0);
      check("reset_chime_cnt", int'(cnt_q), 0);
      check("reset_done", int'(done_q), 0);
      rst = 1'b0;

      // Hold hour 0 after reset: nothing happens
      run_seq("hold0", 0, 0, 10);

      // 24 h mode, 0 -> 13: 13 flashes
      curHour = 8'd13; mode_12h = 1'b0;
      run_seq("h13_24h", 13, 13, 3);

      // 23 is quiet on u_dut; u_loud in 12 h mode gives 11
      curHour = 8'd23; mode_12h = 1'b1;
      run_seq("h23_12h", 0, 11, 3);

      // 12 h mode: 13 -> 1 flash, 12 -> 12 flashes, 0 -> 12 (quiet on u_dut)
      curHour = 8'd13;
      run_seq("h13_12h", 1, 1, 3);
      curHour = 8'd12;
      run_seq("h12_12h", 12, 12, 3);
      curHour = 8'd0;
      run_seq("h0_12h", 0, 12, 3);

      // Quiet window boundaries, 24 h mode
      mode_12h = 1'b0;
      curHour = 8'd21;
      run_seq("h21", 21, 21, 3);
      curHour = 8'd22;
      run_seq("h22_quiet_start", 0, 22, 3);
      curHour = 8'd6;
      run_seq("h6_quiet", 0, 6, 3);
      curHour = 8'd23;
      run_seq("h23_quiet", 0, 23, 3);
      curHour = 8'd6;
      run_seq("h6_again", 0, 6, 3);
      curHour = 8'd7;
      run_seq("h7_quiet_end", 7, 7, 3);

      // Invalid hour
      curHour = 8'd30;
      run_seq("h30_invalid", 0, 0, 8);

      // Restart during the third ON flash: 17 (5 flashes, 12 h) -> 14 (2)
      mode_12h = 1'b1;
      curHour  = 8'd17;
      for (int i = 0; i < 2 * PER + 1; i++) @(negedge clk);
      check("restart_third_on_light", int'(tl_q), 1);
      check("restart_third_on_cnt", int'(cnt_q), 3);
      curHour = 8'd14;
      run_seq("restart_h14", 2, 2, 3);

      // Drop enable mid-sequence
      mode_12h = 1'b0;
      curHour  = 8'd15;
      for (int i = 0; i < PER + 2; i++) @(negedge clk);
      check("pre_disable_busy", int'(busy_q), 1);
      enable = 1'b0;
      @(negedge clk);
      check("disable_time_light", int'(tl_q), 0);
      check("disable_busy", int'(busy_q), 0);
      check("disable_chime_cnt", int'(cnt_q), 0);
      check("disable_done", int'(done_q), 0);
      enable = 1'b1;
      run_seq("after_reenable", 0, 0, 8);

      // Asynchronous reset mid-sequence
      curHour = 8'd16;
      for (int i = 0; i < 3; i++) @(negedge clk);
      check("pre_reset_busy", int'(busy_q), 1);
      #2 rst = 1'b1;
      #1;
      check("async_reset_time_light", int'(tl_q), 0);
      check("async_reset_busy", int'(busy_q), 0);
      check("async_reset_chime_cnt", int'(cnt_q), 0);
      check("async_reset_done", int'(done_q), 0);
      @(negedge clk);
      rst     = 1'b0;
      curHour = 8'd18;
      run_seq("post_reset_change", 0, 0, 8);

      // Primed again: next change chimes (19 in 12 h -> 7)
      mode_12h = 1'b1;
      curHour  = 8'd19;
      run_seq("post_reset_h19", 7, 7, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
